// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// The optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
package serial_add_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width for a given operand width; never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit full-adder slice shared by every bit position of the serial add.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of a single bit pair
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice walks a WIDTH-bit add LSB-first,
// one bit per cycle, with the carry held in a register between cycles.
// Defining SERIAL_ADD_OVF_EN adds the registered signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] s_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             co_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic sum_bit_d;
  logic carry_d;
  logic last_c;

  // The single adder cell, fed by the low bits of the operand shift registers
  fa_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (sum_bit_d),
    .co (carry_d)
  );

  // Final bit position of the current add
  assign last_c = (cnt_q == LAST_CNT);

  // Controller FSM with datapath registers; outputs are updated alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= ci;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          carry_q <= carry_d;
          s_q     <= WIDTH'({sum_bit_d, s_q} >> 1);
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_c) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            co_q    <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q is the carry into the MSB, carry_d the carry out of it
            ovf_q   <= carry_q ^ carry_d;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 1, 8 and 32 against an arithmetic model.
// Overflow checks are included when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_v [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic        ci_v    [3];

  logic        busy1, done1, co1;
  logic [0:0]  s1;
  logic        busy8, done8, co8;
  logic [7:0]  s8;
  logic        busy32, done32, co32;
  logic [31:0] s32;
`ifdef SERIAL_ADD_OVF_EN
  logic        ovf1, ovf8, ovf32;
`endif

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][0:0]), .b(b_v[0][0:0]),
    .ci(ci_v[0]), .busy(busy1), .done(done1), .s(s1), .co(co1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_add_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
    .ci(ci_v[1]), .busy(busy8), .done(done8), .s(s8), .co(co8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .ci(ci_v[2]), .busy(busy32), .done(done32), .s(s32), .co(co32)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf32)
`endif
  );

  always #5 clk = ~clk;

  function automatic int width_of(input int k);
    case (k)
      0:       return 1;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic logic get_busy(input int k);
    case (k)
      0:       return busy1;
      1:       return busy8;
      default: return busy32;
    endcase
  endfunction

  function automatic logic get_done(input int k);
    case (k)
      0:       return done1;
      1:       return done8;
      default: return done32;
    endcase
  endfunction

  function automatic logic get_co(input int k);
    case (k)
      0:       return co1;
      1:       return co8;
      default: return co32;
    endcase
  endfunction

  function automatic logic [31:0] get_s(input int k);
    case (k)
      0:       return 32'(s1);
      1:       return 32'(s8);
      default: return s32;
    endcase
  endfunction

`ifdef SERIAL_ADD_OVF_EN
  function automatic logic get_ovf(input int k);
    case (k)
      0:       return ovf1;
      1:       return ovf8;
      default: return ovf32;
    endcase
  endfunction
`endif

  // Reference: full-precision sum, truncated to WIDTH+1 bits
  function automatic longint ref_sum(input int w, input logic [31:0] av, input logic [31:0] bv,
                                     input logic civ);
    longint m;
    m = (longint'(1) << w) - 1;
    return ((longint'(av) & m) + (longint'(bv) & m) + longint'(civ)) & ((m << 1) | 1);
  endfunction

  // Reference: signed overflow when the two's-complement sum leaves the WIDTH-bit range
  function automatic logic ref_ovf(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic civ);
    longint m, half, sa, sb, t;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = longint'(av) & m;
    sb   = longint'(bv) & m;
    if (sa >= half) sa = sa - (m + 1);
    if (sb >= half) sb = sb - (m + 1);
    t = sa + sb + longint'(civ);
    return (t > half - 1) || (t < -half);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge; checks the accepting edge's effect
  task automatic issue(input int k, input logic [31:0] av, input logic [31:0] bv, input logic civ,
                       input string tag);
    start_v[k] = 1'b1;
    a_v[k]     = av;
    b_v[k]     = bv;
    ci_v[k]    = civ;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    chk({tag, "_acc_busy"}, 64'(get_busy(k)), 64'd1);
    chk({tag, "_acc_done"}, 64'(get_done(k)), 64'd0);
    chk({tag, "_acc_s"},    64'(get_s(k)),    64'd0);
  endtask

  // Wait (bounded) for done and check the number of cycles it took
  task automatic wait_done(input int k, input int exp_cycles, input string tag);
    int n;
    n = 0;
    while (!get_done(k) && n < exp_cycles + 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"},  64'(n),           64'(exp_cycles));
    chk({tag, "_busy"}, 64'(get_busy(k)), 64'd0);
  endtask

  task automatic check_result(input int k, input logic [31:0] av, input logic [31:0] bv,
                              input logic civ, input string tag);
    int     w;
    longint e;
    w = width_of(k);
    e = ref_sum(w, av, bv, civ);
    chk({tag, "_s"},  64'(get_s(k)),  64'(e & ((longint'(1) << w) - 1)));
    chk({tag, "_co"}, 64'(get_co(k)), 64'((e >> w) & 1));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 64'(get_ovf(k)), 64'(ref_ovf(w, av, bv, civ)));
`endif
  endtask

  task automatic add(input int k, input logic [31:0] av, input logic [31:0] bv, input logic civ,
                     input string tag);
    issue(k, av, bv, civ, tag);
    wait_done(k, width_of(k), tag);
    check_result(k, av, bv, civ, tag);
  endtask

  initial begin
    logic [31:0] ra, rb, mask;
    logic        rc;
    clk   = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      a_v[k]     = '0;
      b_v[k]     = '0;
      ci_v[k]    = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy_w%0d", width_of(k)), 64'(get_busy(k)), 64'd0);
      chk($sformatf("rst_done_w%0d", width_of(k)), 64'(get_done(k)), 64'd0);
      chk($sformatf("rst_s_w%0d",    width_of(k)), 64'(get_s(k)),    64'd0);
      chk($sformatf("rst_co_w%0d",   width_of(k)), 64'(get_co(k)),   64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add, then done must drop after one cycle and the result must hold
    add(1, 32'h03, 32'h05, 1'b0, "t1");
    @(posedge clk); #1;
    chk("t1_done_pulse", 64'(get_done(1)), 64'd0);
    chk("t1_s_hold",     64'(get_s(1)),    64'h08);

    // Carry out, then carry in only (issued straight from DONE)
    add(1, 32'hFF, 32'h01, 1'b0, "t2a");
    add(1, 32'h00, 32'h00, 1'b1, "t2b");
    @(posedge clk); #1;

    // start during RUN is ignored
    issue(1, 32'h12, 32'h34, 1'b0, "t3");
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_v[1] = 1'b1;
    a_v[1]     = 32'hAA;
    b_v[1]     = 32'h55;
    ci_v[1]    = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    wait_done(1, 5, "t3");
    check_result(1, 32'h12, 32'h34, 1'b0, "t3");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t3_no_extra_done%0d", i), 64'(get_done(1)), 64'd0);
      chk($sformatf("t3_idle_busy%0d", i),     64'(get_busy(1)), 64'd0);
    end

    // Back-to-back: new start accepted in the DONE cycle
    add(1, 32'h01, 32'h02, 1'b0, "t4a");
    add(1, 32'h10, 32'h20, 1'b0, "t4b");
    @(posedge clk); #1;

    // Reset in the middle of RUN discards the partial result
    issue(1, 32'h5A, 32'h3C, 1'b1, "t5");
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(get_busy(1)), 64'd0);
    chk("t5_rst_done", 64'(get_done(1)), 64'd0);
    chk("t5_rst_s",    64'(get_s(1)),    64'd0);
    chk("t5_rst_co",   64'(get_co(1)),   64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add(1, 32'h5A, 32'h3C, 1'b1, "t5_fresh");

    // Signed overflow boundaries (s/co checked in every build)
    add(1, 32'h7F, 32'h01, 1'b0, "t6a");
    add(1, 32'hFF, 32'h01, 1'b0, "t6b");
    add(1, 32'h80, 32'h80, 1'b0, "t6c");
    @(posedge clk); #1;

    // Randomized sweep on every width
    for (int k = 0; k < 3; k++) begin
      mask = (width_of(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << width_of(k)) - 32'd1);
      for (int i = 0; i < 16; i++) begin
        ra = $urandom() & mask;
        rb = $urandom() & mask;
        rc = 1'($urandom_range(1, 0));
        add(k, ra, rb, rc, $sformatf("sweep_w%0d_%0d", width_of(k), i));
      end
      add(k, mask, mask, 1'b1, $sformatf("sweep_w%0d_max", width_of(k)));
      @(posedge clk); #1;
      chk($sformatf("sweep_w%0d_done_drop", width_of(k)), 64'(get_done(k)), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
